// File: rtl/xup_piso_shifter.sv
// xup_piso_shifter: valid/ready loaded parallel-in serial-out transmitter with done pulse
`timescale 1ns/1ps
module xup_piso_shifter #(
    parameter int SIZE      = 8,
    parameter int DELAY     = 3,
    parameter bit MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] d,
    input  logic            load_valid,
    output logic            load_ready,
    input  logic            shift_en,
    output logic            sout,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(SIZE + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t          state, state_nx;
    logic [SIZE-1:0] sr;
    logic [SIZE-1:0] sr_shifted;
    logic [CW-1:0]   cnt;
    logic            load, step, last, next_bit;
    assign load       = state == IDLE && load_valid;
    assign step       = state == SHIFT && shift_en;
    assign last       = cnt == CW'(1);
    assign sr_shifted = MSB_FIRST ? {sr[SIZE-2:0], 1'b0} : {1'b0, sr[SIZE-1:1]};
    assign next_bit   = MSB_FIRST ? sr[SIZE-2] : sr[1];
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= #DELAY IDLE;
        else       state <= #DELAY state_nx;
    end
    always_comb begin
        state_nx = load ? SHIFT : (step && last) ? DONE : (state == DONE) ? IDLE : state;
    end
    always_comb begin
        load_ready = state == IDLE;
        busy       = state == SHIFT;
        done       = state == DONE;
    end
    // sout is registered so no input reaches an output combinationally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr   <= #DELAY '0;
            cnt  <= #DELAY '0;
            sout <= #DELAY 1'b0;
        end else if (load) begin
            sr   <= #DELAY d;
            cnt  <= #DELAY CW'(SIZE);
            sout <= #DELAY MSB_FIRST ? d[SIZE-1] : d[0];
        end else if (step) begin
            sr   <= #DELAY sr_shifted;
            cnt  <= #DELAY cnt - CW'(1);
            sout <= #DELAY last ? 1'b0 : next_bit;
        end else if (state == DONE) begin
            sout <= #DELAY 1'b0;
        end
    end
endmodule

// File: doc/xup_piso_shifter.md
Name: xup_piso_shifter

Overview:
- Parallel-in, serial-out transmitter. Accepts a SIZE-bit word through a valid/ready load handshake.
- Shifts the word out one bit per enabled clock on sout, then pulses done.
- Serves as the transmit end paired with the team's serial-capture/deserializing register blocks. Sits between a parallel data source (register or counter) and a one-wire serial link.

Parameters:
SIZE, 8, word width in bits; legal range 2..32
DELAY, 3, intra-assignment delay (#DELAY) on every registered update, in timescale units
MSB_FIRST, 1, 1 = bit SIZE-1 is transmitted first; 0 = bit 0 is transmitted first

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
d  input  SIZE  parallel word to transmit
load_valid  input  1  source has a word on d
load_ready  output  1  shifter can accept a word this cycle
shift_en  input  1  advance to next bit at this clock edge
sout  output  1  current serial bit
busy  output  1  word in flight
done  output  1  one-cycle pulse after the last bit has been shifted

Behaviour:
- Reset is asynchronous and active-high. The state machine goes to IDLE immediately, without waiting for clk.
- Reset values: sout=0, load_ready=1, busy=0, done=0, internal shift register=0, bit counter=0.
- Reset asserted mid-word aborts the word. No done pulse is produced.
- All register updates use <= #DELAY.
- Outputs are registered or decoded from state only. There is no combinational path from any input to any output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - load_ready=1, busy=0, sout=0.
  - A rising edge with load_valid=1 captures d into the shift register and loads counter=SIZE.
  - Same edge: sout <= first bit (d[SIZE-1] if MSB_FIRST, else d[0]), and the state goes to SHIFT.
  - shift_en is ignored in IDLE.
- SHIFT:
  - load_ready=0, busy=1. load_valid and d are ignored.
  - Edge with shift_en=1 and counter>1:
    - shift register moves one position (left if MSB_FIRST, else right, zero-filled);
    - sout <= next bit;
    - counter decrements.
  - Edge with shift_en=1 and counter==1: state goes to DONE, sout <= 0, counter <= 0.
  - Edge with shift_en=0: everything holds. Stalls of any length are allowed.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, load_ready=0, sout=0.
  - Next edge returns unconditionally to IDLE.
  - Minimum spacing between accepted words is SIZE+2 cycles.
- Latency with shift_en held high: load accepted at edge E0. Bit i (i=0..SIZE-1, transmit order) is on sout from edge E0+i to edge E0+i+1. done=1 between edge E0+SIZE and E0+SIZE+1.
- Simultaneous load_valid=1 and shift_en=1 in IDLE: load only; the first bit is still presented for one full enabled cycle.
- The counter is $clog2(SIZE+1) bits wide. The counter has no wrap-around: it never decrements below 0.

Test Plan:
- Reset, then assert reset asynchronously between clock edges -> all outputs take reset values before the next edge; load_ready=1, sout=0, busy=0, done=0.
- SIZE=8, MSB_FIRST=1, d=8'h2D, load_valid for one cycle, shift_en held 1:
  - sout over 8 cycles = 0,0,1,0,1,1,0,1;
  - done=1 exactly in cycle 9;
  - load_ready=0 for cycles 1..9, then 1.
- MSB_FIRST=0, d=8'h2D, shift_en=1 -> sout sequence 1,0,1,1,0,1,0,0, then done pulse.
- MSB_FIRST=1, d=8'hF0, shift_en toggled 1,0,0,1,1,0,1... -> each bit holds through the 0 cycles; sequence is still 1,1,1,1,0,0,0,0; done follows the 8th enabled edge.
- load_valid held 1 with new d=8'h55 during SHIFT of 8'hA5:
  - 8'h55 is ignored until IDLE;
  - 8'hA5 bits come out unchanged;
  - 8'h55 is accepted on the first IDLE edge, SIZE+2 cycles after the first load.
- Reset asserted after the 3rd bit of 8'hFF -> sout=0 and busy=0 immediately; no done pulse; next load of 8'h81 transmits 1,0,0,0,0,0,0,1.
